edu_ctrl_sequencer: RTL
=======================

// Module: edu_ctrl_sequencer
// PURPOSE
//  Next-generation EDULENT control sequencer: decodes i_opcode and steps the datapath via transfer commands.
//  Adds a memory req/ack handshake with timeout, a vectored interrupt, single-step and halt.
//  Sits between the IR and the datapath/memory interface; encodings of the existing ISA sheet are kept.
// PARAMETERS
//  OPC_W       8      opcode width; only the low 8 bits are decoded, upper bits must be 0 (else NOP).
//  MEM_TIMEOUT 15     max cycles o_mem_req may wait for i_mem_ack before bus error (1..255).
//  IRQ_EN_RST  0      reset value of the internal interrupt-enable flag IE.
// PORTS
//  i_clk           in   1      clock
//  i_rstn          in   1      asynchronous, active-low reset
//  i_opcode        in   OPC_W  current IR contents
//  i_mem_ack       in   1      memory completed the current req (1-cycle pulse)
//  i_irq           in   1      level interrupt request
//  i_step_en       in   1      single-step mode enable
//  i_step          in   1      step pulse: release one instruction in step mode
//  o_transfer_cmd  out  4      0 none,1 MA<-PC,2 MD<-M[MA],3 IR<-MD,4 MA<-MD,5 A/AP<-MD,6 MA<-AP,7 MA<-SP,
//                              8 MD<-A/AP,9 M[MA]<-MD,A A/AP<-R,B PC<-MD,C A<-IN,D OUT<-A,E PC<-AP,F MD<-PC
//  o_mem_req       out  1      memory access pending (cmd 2 or 9)
//  o_mem_we        out  1      1 = write access (cmd 9)
//  o_inc_pc        out  1      PC+1, one cycle
//  o_inc_dec_sp    out  2      01 SP+1, 10 SP-1, one cycle
//  o_alu_calculate out  1      ALU evaluates (ALU state only)
//  o_alu_res_to_ap out  1      ALU result targets AP (opcodes 0x3B/0x4B)
//  o_reset_ir      out  1      clear IR (fetch start)
//  o_load_vector   out  1      PC <- IRQ vector
//  o_irq_ack       out  1      interrupt accepted, one-cycle pulse
//  o_halted        out  1      core halted (HALT opcode or bus error)
//  o_bus_err       out  1      sticky: memory timeout occurred
// BEHAVIOUR
//  - Reset: state RESET, IE=IRQ_EN_RST, all outputs 0. Next cycle -> BOUNDARY.
//  - BOUNDARY (instruction boundary, outputs 0): priority bus_err > irq > step > fetch.
//    i_irq&IE -> IRQ_DEC_SP; else if i_step_en&!i_step -> stay; else -> MA_PC.
//  - Fetch: MA_PC(cmd1,o_reset_ir) -> RD_PC(cmd2,req) -> IR_MD(cmd3) -> execute sequence per ISA sheet,
//    identical microstep order to the current ISA (operand fetch via MA_PC_OP/RD_OP, ALU -> A_R/AP_R, etc.).
//  - Every read state (cmd2) and write state (cmd9) is a wait state: o_mem_req=1, cmd held stable until
//    i_mem_ack; o_inc_pc / o_inc_dec_sp of that state assert only in the ack cycle; advance on next edge.
//  - Wait counter clears on entering a wait state; if MEM_TIMEOUT cycles pass without ack -> o_bus_err=1
//    (sticky), HALT. Ack in exactly cycle MEM_TIMEOUT counts as success.
//  - Opcode 0xF8 sets IE, 0xF9 clears IE (both single IR_MD then BOUNDARY). 0x02 -> HALT.
//  - Undecoded opcode: NOP, returns to BOUNDARY after IR_MD.
//  - Interrupt entry: IRQ_DEC_SP(sp 10) -> IRQ_MA_SP(cmd7) -> IRQ_MD_PC(cmdF) -> IRQ_STORE(cmd9,we,wait)
//    -> IRQ_VEC(o_load_vector=1, o_irq_ack=1, IE<=0) -> BOUNDARY. Total 5 cycles + write wait.
//  - HALT: o_halted=1, outputs else 0; exits to IRQ_DEC_SP on i_irq&IE unless o_bus_err (reset only).
//  - Step mode: one full instruction per i_step pulse; i_step outside BOUNDARY ignored.
//  - i_rstn low mid-access: immediate return to RESET; pending req dropped same cycle.
//  - o_alu_calculate only in ALU state; all other outputs decoded from current state (Moore).
// TESTING
//  - Reset, ack=1 combinational-next-cycle, opcode 0x19 imm 0x5A -> cmd seq 1,2,3,1,2,5; inc_pc 2x.
//  - Read with ack after 4 cycles -> cmd 2 held 5 cycles, inc_pc exactly once in ack cycle.
//  - No ack, MEM_TIMEOUT=15 -> o_bus_err and o_halted at cycle 15 after req; irq ignored afterwards.
//  - IE set (0xF8), i_irq=1 mid-0x31 -> instruction completes, then cmds 7,F,9, load_vector, irq_ack 1 cycle.
//  - i_step_en=1: sequencer waits at BOUNDARY; one i_step pulse -> exactly one instruction then wait.
//  - Opcode 0x02 -> o_halted=1; i_irq with IE=0 -> stays halted; i_rstn pulse -> RESET then fetch.

Source files
------------

// File: rtl/edu_ctrl_sequencer.sv
// Purpose     : EDULENT control sequencer; decodes the IR and steps the datapath with transfer commands,
//               adds a memory req/ack handshake with timeout, a vectored interrupt, single-step and halt.
// Latency/bp  : one microstep per cycle; read/write states stall until i_mem_ack (or bus error on timeout).
//
// Ports:
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_opcode             current IR contents (only the low 8 bits decode; upper bits must be zero)
//   i_mem_ack            memory completed the pending access (1-cycle pulse)
//   i_irq                level interrupt request, taken at instruction boundary or from HALT when IE=1
//   i_step_en, i_step    single-step mode enable / release pulse (only sampled at the instruction boundary)
//   o_transfer_cmd       register-transfer command to the datapath (0 = none)
//   o_mem_req, o_mem_we  memory access pending / access is a write
//   o_inc_pc, o_inc_dec_sp   PC increment, SP increment (01) / decrement (10)
//   o_alu_calculate, o_alu_res_to_ap   ALU evaluate strobe / result goes to AP instead of A
//   o_reset_ir, o_load_vector, o_irq_ack   IR clear at fetch start, PC <- vector, interrupt accepted
//   o_halted, o_bus_err  core halted / sticky memory timeout flag
module edu_ctrl_sequencer #(
  parameter int OPC_W       = 8,
  parameter int MEM_TIMEOUT = 15,
  parameter bit IRQ_EN_RST  = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_mem_ack,
  input  logic             i_irq,
  input  logic             i_step_en,
  input  logic             i_step,
  output logic [3:0]       o_transfer_cmd,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_inc_pc,
  output logic [1:0]       o_inc_dec_sp,
  output logic             o_alu_calculate,
  output logic             o_alu_res_to_ap,
  output logic             o_reset_ir,
  output logic             o_load_vector,
  output logic             o_irq_ack,
  output logic             o_halted,
  output logic             o_bus_err
);

  typedef enum logic [4:0] {
    S_RESET, S_BOUNDARY, S_MA_PC, S_RD_PC, S_IR_MD,
    S_MA_PC_OP, S_RD_OP, S_MA_MD, S_RD_DAT, S_MA_AP, S_LD_A,
    S_ALU, S_A_R, S_AP_R, S_MD_A, S_WR_MEM,
    S_PC_MD, S_PC_AP, S_IN_A, S_OUT_A,
    S_DEC_SP, S_MA_SP, S_RD_SP,
    S_IRQ_DEC_SP, S_IRQ_MA_SP, S_IRQ_MD_PC, S_IRQ_STORE, S_IRQ_VEC,
    S_HALT
  } state_t;

  // Instruction classes: which shared microstep path the execute phase follows.
  typedef enum logic [3:0] {
    C_NOP, C_LDI, C_LDD, C_STD, C_ALUI, C_ALU, C_JMP, C_JAP,
    C_LDAP, C_PUSH, C_POP, C_RET, C_IN, C_OUT
  } cls_t;

  localparam int         HI_W     = (OPC_W > 8) ? OPC_W - 8 : 1;
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  cls_t       cls_q, dec_cls;
  logic       ap_q, dec_ap;
  logic       ie_q;
  logic       bus_err_q;
  logic [7:0] wait_cnt;
  logic [HI_W-1:0] opc_hi;
  logic [7:0] opc8;
  logic       opc_ok;
  logic       dec_halt, dec_set_ie, dec_clr_ie;
  logic       is_wait, tmo;

  generate
    if (OPC_W > 8) begin : g_hi
      assign opc_hi = i_opcode[OPC_W-1:8];
    end else begin : g_nohi
      assign opc_hi = '0;
    end
  endgenerate

  assign opc8   = i_opcode[7:0];
  assign opc_ok = (opc_hi == '0);

  // Opcode decode; anything not listed (or with upper bits set) executes as NOP.
  always_comb begin
    dec_cls    = C_NOP;
    dec_ap     = 1'b0;
    dec_halt   = 1'b0;
    dec_set_ie = 1'b0;
    dec_clr_ie = 1'b0;
    if (opc_ok) begin
      case (opc8)
        8'h02: dec_halt   = 1'b1;
        8'hF8: dec_set_ie = 1'b1;
        8'hF9: dec_clr_ie = 1'b1;
        8'h19: dec_cls    = C_LDI;
        8'h1A: dec_cls    = C_LDD;
        8'h29: dec_cls    = C_STD;
        8'h31: dec_cls    = C_ALUI;
        8'h3B: begin dec_cls = C_ALUI; dec_ap = 1'b1; end
        8'h41: dec_cls    = C_ALU;
        8'h4B: begin dec_cls = C_ALU;  dec_ap = 1'b1; end
        8'h50: dec_cls    = C_IN;
        8'h51: dec_cls    = C_OUT;
        8'h60: dec_cls    = C_JMP;
        8'h61: dec_cls    = C_JAP;
        8'h6A: dec_cls    = C_LDAP;
        8'h70: dec_cls    = C_PUSH;
        8'h71: dec_cls    = C_POP;
        8'h72: dec_cls    = C_RET;
        default: ;
      endcase
    end
  end

  assign is_wait = state inside {S_RD_PC, S_RD_OP, S_RD_DAT, S_RD_SP, S_WR_MEM, S_IRQ_STORE};
  // wait_cnt counts completed wait cycles, so the MEM_TIMEOUT-th cycle is the last chance for ack.
  assign tmo     = is_wait && !i_mem_ack && (wait_cnt == TMO_LAST);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_RESET;
      cls_q     <= C_NOP;
      ap_q      <= 1'b0;
      ie_q      <= IRQ_EN_RST;
      bus_err_q <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        wait_cnt <= '0;
      end else if (is_wait) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (state == S_IR_MD) begin
        cls_q <= dec_cls;
        ap_q  <= dec_ap;
        if (dec_set_ie) ie_q <= 1'b1;
        if (dec_clr_ie) ie_q <= 1'b0;
      end
      if (state == S_IRQ_VEC) ie_q <= 1'b0;
      if (tmo) bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:    state_nxt = S_BOUNDARY;
      S_BOUNDARY: begin
        if (bus_err_q)                state_nxt = S_HALT;
        else if (i_irq && ie_q)       state_nxt = S_IRQ_DEC_SP;
        else if (i_step_en && !i_step) state_nxt = S_BOUNDARY;
        else                          state_nxt = S_MA_PC;
      end
      S_MA_PC:    state_nxt = S_RD_PC;
      S_RD_PC:    if (i_mem_ack) state_nxt = S_IR_MD;
      S_IR_MD: begin
        if (dec_halt) begin
          state_nxt = S_HALT;
        end else begin
          case (dec_cls)
            C_LDI, C_LDD, C_STD, C_ALUI, C_JMP: state_nxt = S_MA_PC_OP;
            C_ALU:          state_nxt = S_ALU;
            C_IN:           state_nxt = S_IN_A;
            C_OUT:          state_nxt = S_OUT_A;
            C_JAP:          state_nxt = S_PC_AP;
            C_LDAP:         state_nxt = S_MA_AP;
            C_PUSH:         state_nxt = S_DEC_SP;
            C_POP, C_RET:   state_nxt = S_MA_SP;
            default:        state_nxt = S_BOUNDARY;
          endcase
        end
      end
      S_MA_PC_OP: state_nxt = S_RD_OP;
      S_RD_OP: begin
        if (i_mem_ack) begin
          case (cls_q)
            C_LDI:        state_nxt = S_LD_A;
            C_LDD, C_STD: state_nxt = S_MA_MD;
            C_ALUI:       state_nxt = S_ALU;
            C_JMP:        state_nxt = S_PC_MD;
            default:      state_nxt = S_BOUNDARY;
          endcase
        end
      end
      S_MA_MD:    state_nxt = (cls_q == C_LDD) ? S_RD_DAT : S_MD_A;
      S_RD_DAT:   if (i_mem_ack) state_nxt = S_LD_A;
      S_MA_AP:    state_nxt = S_RD_DAT;
      S_ALU:      state_nxt = ap_q ? S_AP_R : S_A_R;
      S_MD_A:     state_nxt = S_WR_MEM;
      S_WR_MEM:   if (i_mem_ack) state_nxt = S_BOUNDARY;
      S_DEC_SP:   state_nxt = S_MA_SP;
      S_MA_SP:    state_nxt = (cls_q == C_PUSH) ? S_MD_A : S_RD_SP;
      S_RD_SP:    if (i_mem_ack) state_nxt = (cls_q == C_RET) ? S_PC_MD : S_LD_A;
      S_LD_A, S_A_R, S_AP_R, S_PC_MD, S_PC_AP, S_IN_A, S_OUT_A, S_IRQ_VEC:
                  state_nxt = S_BOUNDARY;
      S_IRQ_DEC_SP: state_nxt = S_IRQ_MA_SP;
      S_IRQ_MA_SP:  state_nxt = S_IRQ_MD_PC;
      S_IRQ_MD_PC:  state_nxt = S_IRQ_STORE;
      S_IRQ_STORE:  if (i_mem_ack) state_nxt = S_IRQ_VEC;
      // A bus error can only be cleared by reset.
      S_HALT:       if (!bus_err_q && i_irq && ie_q) state_nxt = S_IRQ_DEC_SP;
      default:      state_nxt = S_BOUNDARY;
    endcase
    if (tmo) state_nxt = S_HALT;
  end

  // Outputs follow the current state; only the PC/SP side effects of a wait state wait for the ack.
  always_comb begin
    o_transfer_cmd  = 4'h0;
    o_mem_req       = 1'b0;
    o_mem_we        = 1'b0;
    o_inc_pc        = 1'b0;
    o_inc_dec_sp    = 2'b00;
    o_alu_calculate = 1'b0;
    o_alu_res_to_ap = 1'b0;
    o_reset_ir      = 1'b0;
    o_load_vector   = 1'b0;
    o_irq_ack       = 1'b0;
    o_halted        = 1'b0;
    case (state)
      S_MA_PC:     begin o_transfer_cmd = 4'h1; o_reset_ir = 1'b1; end
      S_RD_PC:     begin o_transfer_cmd = 4'h2; o_mem_req = 1'b1; o_inc_pc = i_mem_ack; end
      S_IR_MD:     o_transfer_cmd = 4'h3;
      S_MA_PC_OP:  o_transfer_cmd = 4'h1;
      S_RD_OP:     begin o_transfer_cmd = 4'h2; o_mem_req = 1'b1; o_inc_pc = i_mem_ack; end
      S_MA_MD:     o_transfer_cmd = 4'h4;
      S_RD_DAT:    begin o_transfer_cmd = 4'h2; o_mem_req = 1'b1; end
      S_MA_AP:     o_transfer_cmd = 4'h6;
      S_LD_A:      o_transfer_cmd = 4'h5;
      S_ALU:       begin o_alu_calculate = 1'b1; o_alu_res_to_ap = ap_q; end
      S_A_R:       o_transfer_cmd = 4'hA;
      S_AP_R:      begin o_transfer_cmd = 4'hA; o_alu_res_to_ap = 1'b1; end
      S_MD_A:      o_transfer_cmd = 4'h8;
      S_WR_MEM:    begin o_transfer_cmd = 4'h9; o_mem_req = 1'b1; o_mem_we = 1'b1; end
      S_PC_MD:     o_transfer_cmd = 4'hB;
      S_PC_AP:     o_transfer_cmd = 4'hE;
      S_IN_A:      o_transfer_cmd = 4'hC;
      S_OUT_A:     o_transfer_cmd = 4'hD;
      S_DEC_SP:    o_inc_dec_sp = 2'b10;
      S_MA_SP:     o_transfer_cmd = 4'h7;
      S_RD_SP: begin
        o_transfer_cmd = 4'h2;
        o_mem_req      = 1'b1;
        o_inc_dec_sp   = i_mem_ack ? 2'b01 : 2'b00;
      end
      S_IRQ_DEC_SP: o_inc_dec_sp = 2'b10;
      S_IRQ_MA_SP:  o_transfer_cmd = 4'h7;
      S_IRQ_MD_PC:  o_transfer_cmd = 4'hF;
      S_IRQ_STORE:  begin o_transfer_cmd = 4'h9; o_mem_req = 1'b1; o_mem_we = 1'b1; end
      S_IRQ_VEC:    begin o_load_vector = 1'b1; o_irq_ack = 1'b1; end
      S_HALT:       o_halted = 1'b1;
      default: ;
    endcase
  end

  assign o_bus_err = bus_err_q;

endmodule
